// File: rtl/multi_lane_reshuffler.sv
// multi_lane_reshuffler: CSR-driven stream engine (lane/byte permute or SpatPar x SpatPar transpose).
// Define RESHUFFLER_STALL_CNT_EN to add the STALL_CNT register at CSR 5.
module multi_lane_reshuffler #(
  parameter int SpatPar      = 4,
  parameter int DataWidth    = 64,
  parameter int RegCount     = 8,
  parameter int RegDataWidth = 32,
  parameter int RegAddrWidth = $clog2(RegCount)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [SpatPar*DataWidth-1:0] data_i,
  input  logic                         data_valid_i,
  output logic                         data_ready_o,
  output logic [SpatPar*DataWidth-1:0] data_o,
  output logic                         data_valid_o,
  input  logic                         data_ready_i,
  input  logic [RegAddrWidth-1:0]      csr_addr_i,
  input  logic [RegDataWidth-1:0]      csr_wr_data_i,
  input  logic                         csr_wr_en_i,
  input  logic                         csr_req_valid_i,
  output logic                         csr_req_ready_o,
  output logic [RegDataWidth-1:0]      csr_rd_data_o,
  output logic                         csr_rsp_valid_o,
  input  logic                         csr_rsp_ready_i
);
  localparam int IdxW  = $clog2(SpatPar);
  localparam int Bytes = DataWidth / 8;
  typedef enum logic [1:0] {IDLE, PASS, FILL, DRAIN} state_t;
  state_t state;
  logic [1:0] mode;
  logic [15:0] beats, job_beats, in_cnt, done_cnt, eff_beats;
  logic [IdxW-1:0] row, col, col_sel;
  logic [DataWidth-1:0] tile [SpatPar][SpatPar];
  logic [DataWidth-1:0] tile_nxt [SpatPar][SpatPar];
  logic [SpatPar*DataWidth-1:0] pass_data, col_data;
  logic [RegDataWidth-1:0] rd_val, stall_val;
  logic [31:0] addr;
  logic csr_acc, csr_wr, start, in_hs, out_hs, last_out;
  logic unused_wdata;
  assign unused_wdata    = ^csr_wr_data_i;
  assign csr_req_ready_o = !(csr_rsp_valid_o && !csr_rsp_ready_i);
  assign csr_acc         = csr_req_valid_i && csr_req_ready_o;
  assign addr            = 32'(csr_addr_i);
  assign csr_wr          = csr_acc && csr_wr_en_i && state == IDLE;
  assign eff_beats       = mode == 2'd3 ? beats & ~16'(SpatPar - 1) : beats;
  assign start           = csr_wr && addr == 32'd2 && csr_wr_data_i[0] && eff_beats != 16'd0;
  assign data_ready_o    = state == FILL ||
                           (state == PASS && in_cnt != job_beats && (!data_valid_o || data_ready_i));
  assign in_hs           = data_valid_i && data_ready_o;
  assign out_hs          = data_valid_o && data_ready_i;
  assign last_out        = done_cnt + 16'd1 == job_beats;
  assign col_sel         = state == DRAIN ? col + IdxW'(1) : '0;
  always_comb begin
    pass_data = data_i;
    for (int k = 0; k < SpatPar; k++)
      for (int b = 0; b < Bytes; b++)
        pass_data[k*DataWidth + b*8 +: 8] =
          mode == 2'd1 ? data_i[(SpatPar-1-k)*DataWidth + b*8 +: 8] :
          mode == 2'd2 ? data_i[k*DataWidth + (Bytes-1-b)*8 +: 8] :
                         data_i[k*DataWidth + b*8 +: 8];
    if (mode == 2'd1)
      for (int k = 0; k < SpatPar; k++)
        pass_data[k*DataWidth +: DataWidth] = data_i[(SpatPar-1-k)*DataWidth +: DataWidth];
  end
  // The incoming row is merged before the column pick so the first drain beat is ready on entry.
  always_comb begin
    tile_nxt = tile;
    if (state == FILL && in_hs)
      for (int k = 0; k < SpatPar; k++) tile_nxt[row][k] = data_i[k*DataWidth +: DataWidth];
    for (int i = 0; i < SpatPar; i++) col_data[i*DataWidth +: DataWidth] = tile_nxt[i][col_sel];
  end
  always_comb begin
    case (addr)
      32'd0:   rd_val = RegDataWidth'(mode);
      32'd1:   rd_val = RegDataWidth'(beats);
      32'd3:   rd_val = RegDataWidth'(state != IDLE);
      32'd4:   rd_val = RegDataWidth'(done_cnt);
      32'd5:   rd_val = stall_val;
      default: rd_val = '0;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      mode            <= '0;
      beats           <= '0;
      job_beats       <= '0;
      in_cnt          <= '0;
      done_cnt        <= '0;
      row             <= '0;
      col             <= '0;
      data_o          <= '0;
      data_valid_o    <= 1'b0;
      csr_rsp_valid_o <= 1'b0;
      csr_rd_data_o   <= '0;
      for (int i = 0; i < SpatPar; i++)
        for (int j = 0; j < SpatPar; j++) tile[i][j] <= '0;
    end else begin
      if (csr_acc && !csr_wr_en_i) begin
        csr_rsp_valid_o <= 1'b1;
        csr_rd_data_o   <= rd_val;
      end else if (csr_rsp_ready_i) csr_rsp_valid_o <= 1'b0;
      if (csr_wr && addr == 32'd0) mode <= csr_wr_data_i[1:0];
      if (csr_wr && addr == 32'd1) beats <= csr_wr_data_i[15:0];
      if (out_hs && done_cnt != 16'hFFFF) done_cnt <= done_cnt + 16'd1;
      if (state == PASS && in_hs) in_cnt <= in_cnt + 16'd1;
      tile <= tile_nxt;
      if (start) begin
        state     <= mode == 2'd3 ? FILL : PASS;
        job_beats <= eff_beats;
        done_cnt  <= '0;
        in_cnt    <= '0;
        row       <= '0;
        col       <= '0;
      end
      case (state)
        PASS: begin
          if (in_hs) begin
            data_valid_o <= 1'b1;
            data_o       <= pass_data;
          end else if (out_hs) data_valid_o <= 1'b0;
          if (out_hs && last_out) state <= IDLE;
        end
        FILL: if (in_hs) begin
          row <= row + IdxW'(1);
          if (row == IdxW'(SpatPar - 1)) begin
            state        <= DRAIN;
            col          <= '0;
            data_valid_o <= 1'b1;
            data_o       <= col_data;
          end
        end
        DRAIN: if (out_hs) begin
          col    <= col + IdxW'(1);
          data_o <= col_data;
          if (col == IdxW'(SpatPar - 1)) begin
            data_valid_o <= 1'b0;
            state        <= last_out ? IDLE : FILL;
          end
        end
        default: ;
      endcase
    end
  end
`ifdef RESHUFFLER_STALL_CNT_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt <= '0;
    else if (start) stall_cnt <= '0;
    else if (data_valid_o && !data_ready_i && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
  assign stall_val = RegDataWidth'(stall_cnt);
`else
  assign stall_val = '0;
`endif
endmodule

// File: tb/tb_multi_lane_reshuffler.sv
// tb_multi_lane_reshuffler: scoreboard bench for multi_lane_reshuffler at SpatPar=4, DataWidth=8.
module tb_multi_lane_reshuffler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] data_i = '0, data_o, csr_wr_data_i = '0, csr_rd_data_o, rd;
  logic data_valid_i = 1'b0, data_ready_o, data_valid_o, data_ready_i = 1'b1;
  logic [2:0] csr_addr_i = '0;
  logic csr_wr_en_i = 1'b0, csr_req_valid_i = 1'b0, csr_req_ready_o;
  logic csr_rsp_valid_o, csr_rsp_ready_i = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] fill_buf [4];
  int fill_n = 0, n_chk = 0, n_err = 0;
  logic [1:0] cur_mode = '0;
  logic drain_chk = 1'b0;
`ifdef RESHUFFLER_STALL_CNT_EN
  localparam logic [31:0] ExpStall = 32'd5;
`else
  localparam logic [31:0] ExpStall = 32'd0;
`endif
  multi_lane_reshuffler #(.SpatPar(4), .DataWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .csr_addr_i(csr_addr_i), .csr_wr_data_i(csr_wr_data_i), .csr_wr_en_i(csr_wr_en_i),
    .csr_req_valid_i(csr_req_valid_i), .csr_req_ready_o(csr_req_ready_o),
    .csr_rd_data_o(csr_rd_data_o), .csr_rsp_valid_o(csr_rsp_valid_o), .csr_rsp_ready_i(csr_rsp_ready_i)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] xform(input logic [1:0] m, input logic [31:0] b);
    logic [31:0] r = b;
    if (m == 2'd1)
      for (int k = 0; k < 4; k++) r[k*8 +: 8] = b[(3-k)*8 +: 8];
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n && data_valid_o && data_ready_i) begin
      if (exp_q.size() == 0) check("spurious_beat", 32'(exp_q.size()), 32'd1);
      else check("beat", data_o, exp_q.pop_front());
      if (drain_chk) check("drain_ready", 32'(data_ready_o), 32'd0);
    end
  end
  task automatic csr_write(input int a, input logic [31:0] d);
    int n = 0;
    csr_addr_i = 3'(a); csr_wr_data_i = d; csr_wr_en_i = 1'b1; csr_req_valid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!csr_req_ready_o && n < 50);
    if (n >= 50) check("csr_wr_timeout", 32'(csr_req_ready_o), 32'd1);
    @(posedge clk); #1;
    csr_req_valid_i = 1'b0; csr_wr_en_i = 1'b0;
  endtask
  task automatic csr_read(input int a, output logic [31:0] d);
    int n = 0;
    csr_addr_i = 3'(a); csr_wr_en_i = 1'b0; csr_req_valid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!csr_req_ready_o && n < 50);
    if (n >= 50) check("csr_rd_timeout", 32'(csr_req_ready_o), 32'd1);
    @(posedge clk); #1;
    csr_req_valid_i = 1'b0;
    @(negedge clk);
    check("rsp_latency", 32'(csr_rsp_valid_o), 32'd1);
    d = csr_rd_data_o;
    @(posedge clk); #1;
  endtask
  task automatic expect_csr(input string tag, input int a, input logic [31:0] exp);
    logic [31:0] v;
    csr_read(a, v);
    check(tag, v, exp);
  endtask
  task automatic start_job(input logic [1:0] m, input logic [15:0] b);
    csr_write(0, 32'(m));
    csr_write(1, 32'(b));
    csr_write(2, 32'd1);
    cur_mode = m;
    fill_n = 0;
  endtask
  task automatic send(input logic [31:0] b);
    int n = 0;
    logic [31:0] t;
    if (cur_mode != 2'd3) exp_q.push_back(xform(cur_mode, b));
    else begin
      fill_buf[fill_n] = b;
      fill_n++;
      if (fill_n == 4) begin
        for (int j = 0; j < 4; j++) begin
          for (int i = 0; i < 4; i++) t[i*8 +: 8] = fill_buf[i][j*8 +: 8];
          exp_q.push_back(t);
        end
        fill_n = 0;
      end
    end
    data_i = b; data_valid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!data_ready_o && n < 100);
    if (n >= 100) check("send_timeout", 32'(data_ready_o), 32'd1);
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    if (cur_mode != 2'd3) check("pass_latency", 32'(data_valid_o), 32'd1);
  endtask
  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #3;
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_ready", 32'(data_ready_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_rsp_valid", 32'(csr_rsp_valid_o), 32'd0);
    check("rst_rd_data", csr_rd_data_o, 32'd0);
    check("rst_req_ready", 32'(csr_req_ready_o), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // identity pass-through, three beats
    start_job(2'd0, 16'd3);
    expect_csr("status_busy", 3, 32'd1);
    send(32'h03020100);
    send(32'h07060504);
    send(32'h0B0A0908);
    wait_drain();
    expect_csr("status_idle_m0", 3, 32'd0);
    expect_csr("done_cnt_m0", 4, 32'd3);
    // lane reversal
    start_job(2'd1, 16'd1);
    send(32'h03020100);
    wait_drain();
    expect_csr("done_cnt_m1", 4, 32'd1);
    // byte reversal within 8-bit lanes leaves the beat unchanged
    start_job(2'd2, 16'd2);
    expect_csr("mode_rb", 0, 32'd2);
    expect_csr("beats_rb", 1, 32'd2);
    send(32'hA1B2C3D4);
    send(32'h55667788);
    wait_drain();
    // zero-length jobs never start
    csr_write(1, 32'd0);
    csr_write(2, 32'd1);
    expect_csr("status_beats0", 3, 32'd0);
    csr_write(0, 32'd3);
    csr_write(1, 32'd3);
    csr_write(2, 32'd1);
    expect_csr("status_m3_round0", 3, 32'd0);
    // transpose, writes ignored while busy
    start_job(2'd3, 16'd4);
    csr_write(0, 32'd1);
    csr_write(1, 32'd9);
    expect_csr("mode_locked", 0, 32'd3);
    expect_csr("beats_locked", 1, 32'd4);
    send(32'h03020100);
    send(32'h07060504);
    send(32'h0B0A0908);
    drain_chk = 1'b1;
    send(32'h0F0E0D0C);
    wait_drain();
    drain_chk = 1'b0;
    expect_csr("status_idle_m3", 3, 32'd0);
    expect_csr("done_cnt_m3", 4, 32'd4);
    expect_csr("read_start", 2, 32'd0);
    expect_csr("read_unmapped", 7, 32'd0);
    // output backpressure
    start_job(2'd0, 16'd1);
    data_ready_i = 1'b0;
    send(32'h13121110);
    repeat (5) begin
      @(negedge clk);
      check("hold_data", data_o, 32'h13121110);
      check("hold_valid", 32'(data_valid_o), 32'd1);
      @(posedge clk);
    end
    #1 data_ready_i = 1'b1;
    wait_drain();
    expect_csr("stall_cnt", 5, ExpStall);
    // reset in the middle of a transpose job
    start_job(2'd3, 16'd8);
    send(32'h23222120);
    send(32'h27262524);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(data_valid_o), 32'd0);
    check("mid_rst_ready", 32'(data_ready_o), 32'd0);
    check("mid_rst_data", data_o, 32'd0);
    check("mid_rst_rsp", 32'(csr_rsp_valid_o), 32'd0);
    fill_n = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_csr("status_after_rst", 3, 32'd0);
    expect_csr("mode_after_rst", 0, 32'd0);
    expect_csr("done_after_rst", 4, 32'd0);
    start_job(2'd3, 16'd4);
    send(32'h33323130);
    send(32'h37363534);
    send(32'h3B3A3938);
    send(32'h3F3E3D3C);
    wait_drain();
    expect_csr("done_cnt_post_rst", 4, 32'd4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
